// File: rtl/chacha_pkg.sv
// Shared widths and FSM state encoding for the ChaCha keystream XOR datapath.
package chacha_pkg;

  localparam int unsigned KEY_W       = 256;
  localparam int unsigned NONCE_W     = 96;
  localparam int unsigned CTR_W       = 32;
  localparam int unsigned BLOCK_BYTES = 64;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFill,
    StXor,
    StErr
  } state_e;

endpackage

// File: rtl/chacha_ks_buffer.sv
// One keystream block held as a byte-wide register file; synchronous write, combinational read.
module chacha_ks_buffer #(
  parameter int unsigned BLOCK_BYTES = 64,
  localparam int unsigned PTR_W = $clog2(BLOCK_BYTES)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [7:0]       i_wr_data,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output logic [7:0]       o_rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [7:0] r_mem [BLOCK_BYTES];

  // Capture one keystream byte per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/chacha_stream_xor.sv
// Byte-stream cipher front end: buffers one ChaCha keystream block at a time and XORs it
// with a valid/ready byte stream, advancing the block counter between blocks.
module chacha_stream_xor
  import chacha_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = chacha_pkg::BLOCK_BYTES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic [CTR_W-1:0]   counter_i,
  output logic [KEY_W-1:0]   blk_key_o,
  output logic [NONCE_W-1:0] blk_nonce_o,
  output logic [CTR_W-1:0]   blk_counter_o,
  output logic               blk_start_o,
  input  logic               blk_ready_i,
  input  logic               blk_done_i,
  input  logic [7:0]         blk_keystream_i,
  input  logic [7:0]         s_data_i,
  input  logic               s_valid_i,
  input  logic               s_last_i,
  output logic               s_ready_o,
  output logic [7:0]         m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned PTR_W = $clog2(BLOCK_BYTES);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(BLOCK_BYTES - 1);

  state_e             r_state;
  logic [KEY_W-1:0]   r_key;
  logic [NONCE_W-1:0] r_nonce;
  logic [CTR_W-1:0]   r_counter;
  logic               r_start;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [7:0]         r_m_data;
  logic               r_m_valid;
  logic               r_m_last;

  logic               w_buf_we;
  logic [PTR_W-1:0]   w_buf_waddr;
  logic [7:0]         w_ks_byte;
  logic               w_in_hs;
  logic               w_out_hs;

  // Byte 0 arrives with done (WAIT); bytes 1..N-1 follow back to back (FILL).
  assign w_buf_we    = ((r_state == StWait) && blk_done_i) || (r_state == StFill);
  assign w_buf_waddr = (r_state == StFill) ? r_wr_ptr : '0;

  chacha_ks_buffer #(
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_ks_buffer (
    .i_clk     (clk_i),
    .i_we      (w_buf_we),
    .i_wr_ptr  (w_buf_waddr),
    .i_wr_data (blk_keystream_i),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_ks_byte)
  );

  assign s_ready_o   = (r_state == StXor) && (!r_m_valid || m_ready_i);
  assign cfg_ready_o = (r_state == StIdle) && !r_m_valid;
  assign w_in_hs     = s_valid_i && s_ready_o;
  assign w_out_hs    = r_m_valid && m_ready_i;

  assign blk_key_o     = r_key;
  assign blk_nonce_o   = r_nonce;
  assign blk_counter_o = r_counter;
  assign blk_start_o   = r_start;
  assign m_data_o      = r_m_data;
  assign m_valid_o     = r_m_valid;
  assign m_last_o      = r_m_last;
  assign busy_o        = (r_state != StIdle);
  assign err_o         = (r_state == StErr);

  // Control FSM together with config, counter, pointers and the output register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= StIdle;
      r_key     <= '0;
      r_nonce   <= '0;
      r_counter <= '0;
      r_start   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      // Drain can happen in any state; a new input handshake below overrides it.
      if (w_out_hs) begin
        r_m_valid <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (cfg_valid_i && cfg_ready_o) begin
            r_key     <= key_i;
            r_nonce   <= nonce_i;
            r_counter <= counter_i;
            r_state   <= StReq;
          end
        end
        StReq: begin
          if (blk_ready_i) begin
            r_start <= 1'b1;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (blk_done_i) begin
            r_wr_ptr <= PTR_W'(1);
            r_state  <= StFill;
          end
        end
        StFill: begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (r_wr_ptr == LastPtr) begin
            r_rd_ptr <= '0;
            r_state  <= StXor;
          end
        end
        StXor: begin
          if (w_in_hs) begin
            r_m_data  <= s_data_i ^ w_ks_byte;
            r_m_last  <= s_last_i;
            r_m_valid <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            // Last wins over block exhaustion: leftover keystream is simply dropped.
            if (s_last_i) begin
              r_state <= StIdle;
            end else if (r_rd_ptr == LastPtr) begin
              if (r_counter == '1) begin
                r_state <= StErr;
              end else begin
                r_counter <= r_counter + CTR_W'(1);
                r_state   <= StReq;
              end
            end
          end
        end
        StErr: begin
          r_state <= StErr;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Self-checking bench: ChaCha20 block generator model plus a stream-level XOR reference.
`timescale 1ns/1ps
module tb_chacha_stream_xor;

  localparam int BB      = 64;
  localparam int TIMEOUT = 500;
  typedef logic [7:0] block_t [BB];

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic [255:0] key_i;
  logic [95:0]  nonce_i;
  logic [31:0]  counter_i;
  logic [255:0] blk_key_o;
  logic [95:0]  blk_nonce_o;
  logic [31:0]  blk_counter_o;
  logic         blk_start_o;
  logic         blk_ready_i;
  logic         blk_done_i;
  logic [7:0]   blk_keystream_i;
  logic [7:0]   s_data_i;
  logic         s_valid_i;
  logic         s_last_i;
  logic         s_ready_o;
  logic [7:0]   m_data_o;
  logic         m_valid_o;
  logic         m_last_o;
  logic         m_ready_i;
  logic         busy_o;
  logic         err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Generator model state
  bit          gen_stall   = 1'b0;
  bit          inject_done = 1'b0;
  bit          gen_active  = 1'b0;
  int          gen_idx     = 0;
  int          gen_wait    = 0;
  int          n_starts    = 0;
  logic [31:0] ctr_log [$];
  block_t      gen_ks;

  // Sink / monitor state
  bit         bp_mode = 1'b0;
  logic [7:0] rx_data [$];
  logic       rx_last [$];
  bit         hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  always #5 clk = ~clk;

  chacha_stream_xor #(.BLOCK_BYTES(BB)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .key_i           (key_i),
    .nonce_i         (nonce_i),
    .counter_i       (counter_i),
    .blk_key_o       (blk_key_o),
    .blk_nonce_o     (blk_nonce_o),
    .blk_counter_o   (blk_counter_o),
    .blk_start_o     (blk_start_o),
    .blk_ready_i     (blk_ready_i),
    .blk_done_i      (blk_done_i),
    .blk_keystream_i (blk_keystream_i),
    .s_data_i        (s_data_i),
    .s_valid_i       (s_valid_i),
    .s_last_i        (s_last_i),
    .s_ready_o       (s_ready_o),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_last_o        (m_last_o),
    .m_ready_i       (m_ready_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  // ---------------- ChaCha20 reference (RFC 8439 block function) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void qr(inout logic [31:0] a, inout logic [31:0] b,
                             inout logic [31:0] c, inout logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
  endfunction

  // Key/nonce byte i sits at bits [8*i +: 8], so state words are plain 32-bit slices.
  function automatic block_t chacha_block(input logic [255:0] key, input logic [95:0] nonce,
                                          input logic [31:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    block_t      b;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
    x = s;
    for (int r = 0; r < 10; r++) begin
      qr(x[0], x[4], x[8],  x[12]); qr(x[1], x[5], x[9],  x[13]);
      qr(x[2], x[6], x[10], x[14]); qr(x[3], x[7], x[11], x[15]);
      qr(x[0], x[5], x[10], x[15]); qr(x[1], x[6], x[11], x[12]);
      qr(x[2], x[7], x[8],  x[13]); qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    for (int k = 0; k < BB; k++) b[k] = x[k/4][8*(k%4) +: 8];
    return b;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- chacha_BLOCK model: start -> latency -> 64 consecutive bytes ----------------
  initial begin
    blk_ready_i = 1'b0; blk_done_i = 1'b0; blk_keystream_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      blk_done_i = 1'b0;
      if (!rst_i) begin
        gen_active = 1'b0; gen_idx = 0;
      end else begin
        if (blk_start_o) begin
          n_starts++;
          ctr_log.push_back(blk_counter_o);
          gen_ks = chacha_block(blk_key_o, blk_nonce_o, blk_counter_o);
          gen_wait = 3; gen_idx = 0; gen_active = 1'b1;
        end
        if (gen_active) begin
          if (gen_wait > 0) gen_wait--;
          else begin
            blk_done_i      = (gen_idx == 0);
            blk_keystream_i = gen_ks[gen_idx];
            gen_idx++;
            if (gen_idx == BB) begin gen_active = 1'b0; gen_idx = 0; end
          end
        end else if (inject_done) begin
          blk_done_i = 1'b1; blk_keystream_i = 8'hAA; inject_done = 1'b0;
        end
      end
      blk_ready_i = !gen_active && !gen_stall;
    end
  end

  // ---------------- output sink: random or constant ready ----------------
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collect accepted output bytes; a stalled byte must stay put until taken.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold stable", {m_valid_o, m_last_o, m_data_o}, {1'b1, hold_l, hold_d});
        if (m_valid_o && m_ready_i) begin
          rx_data.push_back(m_data_o);
          rx_last.push_back(m_last_o);
        end
        hold_v = m_valid_o && !m_ready_i;
        hold_d = m_data_o;
        hold_l = m_last_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                        output bit ok);
    int t = 0;
    @(posedge clk); #1;
    cfg_valid_i = 1'b1; key_i = k; nonce_i = n; counter_i = c;
    @(negedge clk);
    while (!cfg_ready_o && t < TIMEOUT) begin t++; @(negedge clk); end
    ok = cfg_ready_o;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg [$], input bit gaps, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < msg.size(); i++) begin
      int t = 0;
      @(posedge clk); #1;
      while (gaps && $urandom_range(0, 2) == 0) begin
        s_valid_i = 1'b0; @(posedge clk); #1;
      end
      s_valid_i = 1'b1; s_data_i = msg[i]; s_last_i = (i == msg.size() - 1);
      @(negedge clk);
      while (!s_ready_o && t < TIMEOUT) begin t++; @(negedge clk); end
      if (!s_ready_o) begin ok = 1'b0; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int t = 0;
    while (rx_data.size() < n && t < 4 * TIMEOUT) begin t++; @(negedge clk); end
    ok = (rx_data.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    @(negedge clk);
    while ((busy_o || m_valid_o) && t < TIMEOUT) begin t++; @(negedge clk); end
    ok = !busy_o && !m_valid_o;
  endtask

  // Reference: byte i = msg[i] ^ keystream of block (ctr + i/64), offset i%64.
  task automatic check_rx(input string tag, input logic [255:0] k, input logic [95:0] n,
                          input logic [31:0] c, input logic [7:0] msg [$], input int n_exp);
    block_t ks;
    check($sformatf("%s count", tag), 256'(rx_data.size()), 256'(n_exp));
    for (int i = 0; i < n_exp && i < rx_data.size(); i++) begin
      if (i % BB == 0) ks = chacha_block(k, n, c + 32'(i / BB));
      check($sformatf("%s byte %0d", tag, i), 256'(rx_data[i]), 256'(msg[i] ^ ks[i % BB]));
      check($sformatf("%s last %0d", tag, i), 256'(rx_last[i]), 256'(i == msg.size() - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},   256'(busy_o),      256'(0));
    check({tag, " err"},    256'(err_o),       256'(0));
    check({tag, " start"},  256'(blk_start_o), 256'(0));
    check({tag, " sready"}, 256'(s_ready_o),   256'(0));
    check({tag, " mvalid"}, 256'(m_valid_o),   256'(0));
    check({tag, " mlast"},  256'(m_last_o),    256'(0));
    check({tag, " mdata"},  256'(m_data_o),    256'(0));
    check({tag, " key"},    blk_key_o,         256'(0));
    check({tag, " nonce"},  256'(blk_nonce_o), 256'(0));
    check({tag, " ctr"},    256'(blk_counter_o), 256'(0));
    check({tag, " cfgrdy"}, 256'(cfg_ready_o), 256'(1));
  endtask

  function automatic void rand_cfg(output logic [255:0] k, output logic [95:0] n);
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32*i +: 32] = $urandom;
  endfunction

  // ---------------- directed sequence ----------------
  string        pt_str = {"Ladies and Gentlemen of the class of '99: If I could offer you only ",
                          "one tip for the future, sunscreen would be it."};
  logic [7:0]   rfc_msg [$];
  logic [7:0]   msg [$];
  logic [255:0] rfc_key, k;
  logic [95:0]  rfc_nonce, n;
  logic [31:0]  c;
  bit           ok;
  logic [7:0]   exp_head [8] = '{8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80};

  initial begin
    rst_i = 1'b1; cfg_valid_i = 1'b0; key_i = '0; nonce_i = '0; counter_i = '0;
    s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
    for (int i = 0; i < pt_str.len(); i++) rfc_msg.push_back(pt_str[i]);
    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_nonce = '0; rfc_nonce[63:56] = 8'h4a;

    // Reset state
    #2 rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_i = 1'b1;

    // RFC 8439 vector, no backpressure
    rx_data.delete(); rx_last.delete(); ctr_log.delete(); n_starts = 0;
    do_cfg(rfc_key, rfc_nonce, 32'd1, ok);  check("rfc cfg", 256'(ok), 256'(1));
    send_msg(rfc_msg, 1'b0, ok);            check("rfc send", 256'(ok), 256'(1));
    wait_rx(114, ok);                       check("rfc rx", 256'(ok), 256'(1));
    wait_idle(ok);                          check("rfc idle", 256'(ok), 256'(1));
    check_rx("rfc", rfc_key, rfc_nonce, 32'd1, rfc_msg, 114);
    for (int i = 0; i < 8; i++)
      check($sformatf("rfc head %0d", i), 256'(rx_data[i]), 256'(exp_head[i]));
    check("rfc tail 112", 256'(rx_data[112]), 256'(8'h87));
    check("rfc tail 113", 256'(rx_data[113]), 256'(8'h4d));
    check("rfc starts", 256'(n_starts), 256'(2));
    check("rfc ctr0", 256'(ctr_log[0]), 256'(1));
    check("rfc ctr1", 256'(ctr_log[1]), 256'(2));
    check("rfc cfgrdy", 256'(cfg_ready_o), 256'(1));

    // Same vector with random backpressure and source gaps
    bp_mode = 1'b1;
    rx_data.delete(); rx_last.delete(); ctr_log.delete(); n_starts = 0;
    do_cfg(rfc_key, rfc_nonce, 32'd1, ok);  check("bp cfg", 256'(ok), 256'(1));
    send_msg(rfc_msg, 1'b1, ok);            check("bp send", 256'(ok), 256'(1));
    wait_rx(114, ok);                       check("bp rx", 256'(ok), 256'(1));
    wait_idle(ok);                          check("bp idle", 256'(ok), 256'(1));
    check_rx("bp", rfc_key, rfc_nonce, 32'd1, rfc_msg, 114);
    check("bp starts", 256'(n_starts), 256'(2));
    bp_mode = 1'b0;

    // Exactly one block: last on byte 63, counter must not advance
    rand_cfg(k, n); c = $urandom_range(0, 32'hFFFF_0000);
    msg.delete(); for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    rx_data.delete(); rx_last.delete(); ctr_log.delete(); n_starts = 0;
    do_cfg(k, n, c, ok);                    check("blk64 cfg", 256'(ok), 256'(1));
    send_msg(msg, 1'b1, ok);                check("blk64 send", 256'(ok), 256'(1));
    wait_rx(64, ok);                        check("blk64 rx", 256'(ok), 256'(1));
    wait_idle(ok);                          check("blk64 idle", 256'(ok), 256'(1));
    check_rx("blk64", k, n, c, msg, 64);
    check("blk64 starts", 256'(n_starts), 256'(1));
    check("blk64 ctr", 256'(blk_counter_o), 256'(c));
    check("blk64 cfgrdy", 256'(cfg_ready_o), 256'(1));

    // Spurious done in IDLE, then generator stalled for 20 cycles in REQ
    inject_done = 1'b1;
    repeat (4) @(negedge clk);
    check("spur busy", 256'(busy_o), 256'(0));
    check("spur mvalid", 256'(m_valid_o), 256'(0));
    check("spur cfgrdy", 256'(cfg_ready_o), 256'(1));
    rand_cfg(k, n); c = $urandom_range(0, 32'hFFFF_0000);
    msg.delete(); for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    rx_data.delete(); rx_last.delete(); ctr_log.delete(); n_starts = 0;
    gen_stall = 1'b1;
    do_cfg(k, n, c, ok);                    check("stall cfg", 256'(ok), 256'(1));
    repeat (20) @(negedge clk);
    check("stall starts", 256'(n_starts), 256'(0));
    check("stall busy", 256'(busy_o), 256'(1));
    gen_stall = 1'b0;
    send_msg(msg, 1'b0, ok);                check("stall send", 256'(ok), 256'(1));
    wait_rx(10, ok);                        check("stall rx", 256'(ok), 256'(1));
    wait_idle(ok);                          check("stall idle", 256'(ok), 256'(1));
    check_rx("stall", k, n, c, msg, 10);
    check("stall starts after", 256'(n_starts), 256'(1));

    // Counter exhaustion: 65-byte message from counter 0xFFFFFFFF
    rand_cfg(k, n); c = 32'hFFFF_FFFF;
    msg.delete(); for (int i = 0; i < 65; i++) msg.push_back(8'($urandom));
    rx_data.delete(); rx_last.delete(); ctr_log.delete(); n_starts = 0;
    do_cfg(k, n, c, ok);                    check("exh cfg", 256'(ok), 256'(1));
    send_msg(msg, 1'b0, ok);                check("exh byte64 blocked", 256'(ok), 256'(0));
    wait_rx(64, ok);                        check("exh rx", 256'(ok), 256'(1));
    check_rx("exh", k, n, c, msg, 64);
    check("exh err", 256'(err_o), 256'(1));
    check("exh sready", 256'(s_ready_o), 256'(0));
    check("exh cfgrdy", 256'(cfg_ready_o), 256'(0));
    check("exh busy", 256'(busy_o), 256'(1));
    check("exh starts", 256'(n_starts), 256'(1));
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check("exh rst err", 256'(err_o), 256'(0));
    @(posedge clk); #1 rst_i = 1'b1;

    // Reset while the buffer is filling at wr_ptr = 30, then a fresh message
    rand_cfg(k, n); c = $urandom_range(0, 32'hFFFF_0000);
    rx_data.delete(); rx_last.delete(); n_starts = 0;
    do_cfg(k, n, c, ok);                    check("mid cfg", 256'(ok), 256'(1));
    begin
      int t = 0;
      @(negedge clk);
      while (!(gen_active && gen_idx == 31) && t < TIMEOUT) begin t++; @(negedge clk); end
      check("mid reach fill 30", 256'(gen_active && gen_idx == 31), 256'(1));
    end
    rst_i = 1'b0; #1;
    check_reset_outputs("mid reset");
    @(posedge clk); @(posedge clk); #1 rst_i = 1'b1;
    rand_cfg(k, n); c = $urandom_range(0, 32'hFFFF_0000);
    msg.delete(); for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    rx_data.delete(); rx_last.delete();
    do_cfg(k, n, c, ok);                    check("mid2 cfg", 256'(ok), 256'(1));
    send_msg(msg, 1'b0, ok);                check("mid2 send", 256'(ok), 256'(1));
    wait_rx(5, ok);                         check("mid2 rx", 256'(ok), 256'(1));
    wait_idle(ok);                          check("mid2 idle", 256'(ok), 256'(1));
    check_rx("mid2", k, n, c, msg, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
